// File: rtl/arb_pkg.sv
// Shared arbiter definitions: source count, one-hot select codes and helpers.
package arb_pkg;

  localparam int N_SRC = 4;

  typedef logic [N_SRC-1:0] sel_t;
  typedef logic [1:0]       idx_t;

  localparam sel_t SEL_NONE = 4'b0000;
  localparam sel_t SEL_1    = 4'b0001;
  localparam sel_t SEL_2    = 4'b0010;
  localparam sel_t SEL_3    = 4'b0100;
  localparam sel_t SEL_4    = 4'b1000;

  function automatic sel_t idx_to_sel(idx_t idx);
    return sel_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arb4_if.sv
// Request/data bus and valid/ready output stage of the four-source arbiter.
interface rr_arb4_if #(
  parameter int WIDTH = 32
);
  import arb_pkg::*;

  sel_t             req;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [WIDTH-1:0] src3;
  logic [WIDTH-1:0] src4;
  sel_t             ack;
  logic             out_valid;
  logic             out_ready;
  sel_t             sel;
  logic [WIDTH-1:0] result;

  // Arbiter side.
  modport slave (
    input  req, src1, src2, src3, src4, out_ready,
    output ack, out_valid, sel, result
  );

  // Requesters plus downstream consumer side.
  modport master (
    output req, src1, src2, src3, src4, out_ready,
    input  ack, out_valid, sel, result
  );

endinterface

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set request scanning from ptr upward, modulo 4.
module rr_pick4
  import arb_pkg::*;
(
  input  sel_t req,
  input  idx_t ptr,
  output sel_t win,
  output idx_t win_idx
);

  logic found;
  idx_t idx;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    win     = SEL_NONE;
    win_idx = ptr;
    found   = 1'b0;
    idx     = ptr;
    for (int o = 0; o < N_SRC; o++) begin
      idx = ptr + idx_t'(o);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win     = idx_to_sel(idx);
        win_idx = idx;
      end
    end
  end

endmodule

// File: rtl/tmux4_1.sv
// One-hot 4:1 multiplexer; an all-zero select yields zero.
module tmux4_1 #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  assign y = ({WIDTH{sel[0]}} & d0) |
             ({WIDTH{sel[1]}} & d1) |
             ({WIDTH{sel[2]}} & d2) |
             ({WIDTH{sel[3]}} & d3);

endmodule

// File: rtl/rr_arb4.sv
// Four-source round-robin arbiter feeding a registered valid/ready output stage
// whose sel tag is always one-hot or zero.
module rr_arb4
  import arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arb4_if.slave    bus
);

  idx_t             ptr_q,       ptr_d;
  logic             out_valid_q, out_valid_d;
  sel_t             sel_q,       sel_d;
  logic [WIDTH-1:0] result_q,    result_d;

  sel_t             win;
  idx_t             win_idx;
  logic             load;
  logic [WIDTH-1:0] mux_y;

  rr_pick4 u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );

  tmux4_1 #(.WIDTH(WIDTH)) u_mux (
    .sel (win),
    .d0  (bus.src1),
    .d1  (bus.src2),
    .d2  (bus.src3),
    .d3  (bus.src4),
    .y   (mux_y)
  );

  // A capture is allowed whenever the output slot is empty or being drained.
  assign load = (|bus.req) && (!out_valid_q || bus.out_ready);

  // rst_n gates ack so no requester sees a grant while the block is held in reset.
  assign bus.ack = (load && rst_n) ? win : SEL_NONE;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    sel_d       = sel_q;
    result_d    = result_q;
    if (load) begin
      out_valid_d = 1'b1;
      sel_d       = win;
      result_d    = mux_y;
      ptr_d       = win_idx + 2'd1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      sel_d       = SEL_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      sel_q       <= SEL_NONE;
      result_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      sel_q       <= sel_d;
      result_q    <= result_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sel       = sel_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Directed and random checks of rr_arb4 against a round-robin reference model.
module tb_rr_arb4;
  import arb_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = 4'b0000;
  logic         ready = 1'b1;
  logic [W-1:0] src [4];

  always #5 clk = ~clk;

  rr_arb4_if #(.WIDTH(W)) bus ();

  assign bus.req       = req;
  assign bus.out_ready = ready;
  assign bus.src1      = src[0];
  assign bus.src2      = src[1];
  assign bus.src3      = src[2];
  assign bus.src4      = src[3];

  rr_arb4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: highest-priority source number, output slot contents.
  int           m_ptr;
  bit           m_valid;
  logic [3:0]   m_sel;
  logic [W-1:0] m_res;

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_sel   = 4'b0000;
    m_res   = '0;
  endtask

  // Winner = first requesting source going around the ring from m_ptr; -1 if none.
  function automatic int pick(logic [3:0] r, int p);
    for (int o = 0; o < 4; o++) begin
      if (r[(p + o) % 4]) return (p + o) % 4;
    end
    return -1;
  endfunction

  task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(string tag, logic [3:0] e_ack);
    check({tag, ":ack"},    W'(bus.ack),       W'(e_ack));
    check({tag, ":valid"},  W'(bus.out_valid), W'(m_valid));
    check({tag, ":sel"},    W'(bus.sel),       W'(m_sel));
    check({tag, ":result"}, bus.result,        m_res);
  endtask

  // Inputs are set before the call; checks at negedge, model advances at posedge.
  task automatic step(string tag);
    int         k;
    bit         load;
    logic [3:0] e_ack;
    @(negedge clk);
    k     = pick(req, m_ptr);
    load  = rst_n && (k >= 0) && (!m_valid || ready);
    e_ack = 4'b0000;
    if (load) e_ack[k] = 1'b1;
    check_outputs(tag, e_ack);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (load) begin
      m_valid = 1'b1;
      m_sel   = 4'b0000;
      m_sel[k] = 1'b1;
      m_res   = src[k];
      m_ptr   = (k + 1) % 4;
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
      m_sel   = 4'b0000;
    end
    #1;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 4; i++) src[i] = $urandom;

    // Reset then idle.
    step("rst0");
    step("rst1");
    rst_n = 1'b1;
    repeat (5) step("idle");

    // Single request from source 3.
    src[2] = 32'h3;
    req    = 4'b0100;
    step("single_ack");
    req = 4'b0000;
    step("single_out");
    check("single_result_const", bus.result, 32'h3);

    // Wrap-around: ptr is now 3, so source 4 wins, then source 1.
    src[0] = 32'hA1;
    src[3] = 32'hA4;
    req    = 4'b1001;
    step("wrap_a");
    step("wrap_b");
    req = 4'b0000;
    step("wrap_drain");
    req = 4'b1000;
    step("to_ptr0");
    req = 4'b0000;
    step("to_ptr0_drain");

    // Round robin with all four requesting.
    for (int i = 0; i < 4; i++) src[i] = W'(i + 1);
    req = 4'b1111;
    repeat (8) step("rr");
    req = 4'b0000;
    step("rr_drain");
    step("rr_empty");

    // Backpressure: ptr back at 0, capture source 2, then stall three cycles.
    req = 4'b0010;
    step("bp_load");
    req   = 4'b1101;
    ready = 1'b0;
    repeat (3) step("bp_stall");
    check("bp_sel_const", W'(bus.sel), W'(SEL_2));
    ready = 1'b1;
    step("bp_release");
    req = 4'b0000;
    step("bp_next");
    step("bp_drain");

    // Reset mid-stall holding a word from source 4.
    req = 4'b1000;
    step("rs_load");
    req   = 4'b1111;
    ready = 1'b0;
    step("rs_stall");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rs_async", 4'b0000);
    step("rs_hold");
    rst_n = 1'b1;
    ready = 1'b1;
    step("rs_after");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      req   = 4'($urandom_range(0, 15));
      ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) src[i] = $urandom;
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arb4.md
# rr_arb4

Four-source round-robin arbiter and output register that generates the one-hot 4-bit select consumed by the team's 32-bit 4:1 one-hot mux (`tmux4_1`). Up to four requesters offer a 32-bit word each. The block picks one per cycle with rotating priority, acknowledges it, and presents the chosen word with its one-hot `sel` tag on a valid/ready output stage. It sits upstream of any shared result path, for example the writeback or bus-return merge, so that `sel` is always a legal one-hot or all-zero code.

## Interface
- `WIDTH`, default 32: data width of each source and of `result`.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous reset, active low.
- `req` input 4: `req[i]` means source i+1 offers data.
- `src1`..`src4` input WIDTH each: data for requesters 0..3.
- `ack` output 4: one-hot, combinational. `ack[i]=1` in the cycle source i+1 is captured.
- `out_valid` output 1: `result` and `sel` hold a word.
- `out_ready` input 1: downstream accepts the word this cycle.
- `sel` output 4: registered one-hot owner of `result`, or 4'b0000 when `out_valid=0`.
- `result` output WIDTH: registered captured data.

## Operation
- Internal state:
  - `ptr`, 2 bits: index with highest priority.
  - Output register: `out_valid`, `sel`, `result`.
- `load = (|req) && (!out_valid || out_ready)`.
- Winner: the first set `req[k]` scanning k = ptr, ptr+1, … modulo 4. `win` is its one-hot code.
- `ack = load ? win : 4'b0000`. At most one bit is set, and `ack` never asserts when `load=0`.
- On a clock edge with `load=1`:
  - `out_valid<=1`, `sel<=win`, `result<=src[k]`.
  - `ptr<=(k+1) mod 4`, which wraps from 3 to 0.
- On a clock edge with `load=0` and `out_valid && out_ready`:
  - `out_valid<=0`, `sel<=0`.
  - `result` holds its value.
  - `ptr` is unchanged.
- Stall (`out_valid && !out_ready`):
  - `sel`, `result` and `ptr` are frozen.
  - `ack=0`.
- Requester contract: hold `req[i]` and `src` stable until `ack[i]`. Data is sampled only in the ack cycle. `req` may drop without ack; the block then simply does not capture that source.
- Priority rotates only on a capture. A source that has just been served is lowest priority next, so with all four requesting continuously the service order is 1, 2, 3, 4, 1, … Worst-case wait is 3 captures.

## Timing
- Reset values: `out_valid=0`, `sel=4'b0000`, `result=0`, `ptr=0` (src1 first). `ack=0` while `rst_n=0`.
- Reset asserted mid-transfer discards the held word immediately, without waiting for a clock edge. The un-acked requests are re-arbitrated after release starting from src1.
- Latency: from `req` sampled with `load=1` to `out_valid=1` is 1 cycle.
- Throughput: 1 word per cycle when `out_ready` is held high. Simultaneous accept and capture in one cycle keeps `out_valid=1` with no bubble.
- `sel` changes only on a clock edge. It is glitch-free and always one-hot or zero.
- `ack` is combinational from `req`, `ptr`, `out_valid` and `out_ready`. `req` must not depend combinationally on `ack`.

## Structure
- Shared package `arb_pkg`:
  - `N_SRC=4`.
  - `SEL_NONE=4'b0000`, `SEL_1=4'b0001`, `SEL_2=4'b0010`, `SEL_3=4'b0100`, `SEL_4=4'b1000`.
  - Typedef `sel_t` (4-bit).
- Sub-module `rr_pick4`: combinational rotating-priority picker (`req`, `ptr` → `win`, winner index). This is the only new sub-module.
- Data path: reuse the existing `tmux4_1`, driven by `win`, to form the next `result`. No second mux is to be written.

## Test plan
- Reset then idle: `rst_n` low for 2 cycles, then `req=0` for 5 cycles. Required: `out_valid=0`, `sel=0000`, `result=0`, `ack=0` throughout.
- Single request: `req=0100`, `src3=32'h3`, `out_ready=1`. Required:
  - `ack=0100` in the same cycle.
  - Next cycle `out_valid=1`, `sel=0100`, `result=3`.
  - `ptr=3` afterwards.
- Round robin: `req=1111`, `src1..src4=1,2,3,4`, `out_ready=1`, held for 8 cycles. Required: `sel` sequence 0001, 0010, 0100, 1000, 0001, …; `result` 1, 2, 3, 4, 1, … with no bubbles.
- Backpressure: a word is valid with `sel=0010`, `result=2` and `req=1101`. Drop `out_ready` for 3 cycles. Required:
  - `sel`, `result` and `out_valid` are stable and `ack=0` during the stall.
  - On `out_ready=1`, `ack=0100` and the next word has `sel=0100`.
- Wrap-around: `ptr=3`, `req=1001`. Required: `ack=1000`, and on the next capture `ack=0001`.
- Reset mid-stall: `out_valid=1`, `sel=1000`, `out_ready=0`, then pulse `rst_n` low asynchronously. Required: `out_valid` and `sel` go to 0 immediately; after release with `req=1111`, the first `ack=0001`.
